// File: rtl/compare_arbiter.sv
// compare_arbiter
//   Four requesters each present a 2-bit operand pair (A, B). A round-robin
//   arbiter grants one requester at a time. It latches that requester's pair
//   and, one cycle later, reports an unsigned magnitude comparison.
//   One transaction takes three cycles: IDLE (grant) -> CAPT -> RESP -> IDLE.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req[3:0]   request per requester (bit i = requester i)
//   a_in[7:0]  operand A, bits [2i+1:2i] belong to requester i
//   b_in[7:0]  operand B, same packing as a_in
//   gnt[3:0]   registered one-hot grant, high for the CAPT cycle
//   busy       high whenever the FSM is not IDLE
//   rsp_valid  one-cycle pulse marking G/E/L/rsp_id as fresh
//   rsp_id     requester that owns the current result
//   G, E, L    A>B, A==B, A<B for the granted pair; held between results
//   done_cnt   saturating count of completed comparisons
module compare_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       rsp_valid,
  output logic [1:0] rsp_id,
  output logic       G,
  output logic       E,
  output logic       L,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] a_lat_q, a_lat_d;
  logic [1:0] b_lat_q, b_lat_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [1:0] rsp_id_q, rsp_id_d;
  logic       g_q, g_d;
  logic       e_q, e_d;
  logic       l_q, l_d;
  logic [7:0] done_cnt_q, done_cnt_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Round-robin search: start one past the last grant and wrap upward.
  // At k == 4 the cast wraps back to last_grant itself. A lone requester
  // that still holds req is therefore re-served.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = 4'b0000;
    last_grant_d = last_grant_q;
    a_lat_d      = a_lat_q;
    b_lat_d      = b_lat_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    g_d          = g_q;
    e_d          = e_q;
    l_d          = l_q;
    done_cnt_d   = done_cnt_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d      = CAPT;
          gnt_d        = 4'b0001 << win_idx;
          last_grant_d = win_idx;
          // Operands are frozen here. Later changes on the bus are ignored.
          a_lat_d      = a_in[{win_idx, 1'b0} +: 2];
          b_lat_d      = b_in[{win_idx, 1'b0} +: 2];
        end
      end
      CAPT: begin
        state_d     = RESP;
        g_d         = (a_lat_q > b_lat_q);
        e_d         = (a_lat_q == b_lat_q);
        l_d         = (a_lat_q < b_lat_q);
        // last_grant still names the requester whose pair was latched.
        rsp_id_d    = last_grant_q;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        if (done_cnt_q != 8'hFF) begin
          done_cnt_d = done_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 4'b0000;
      last_grant_q <= 2'd3;
      a_lat_q      <= 2'd0;
      b_lat_q      <= 2'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 2'd0;
      g_q          <= 1'b0;
      e_q          <= 1'b0;
      l_q          <= 1'b0;
      done_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      a_lat_q      <= a_lat_d;
      b_lat_q      <= b_lat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      g_q          <= g_d;
      e_q          <= e_d;
      l_q          <= l_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign G         = g_q;
  assign E         = e_q;
  assign L         = l_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter
//   Drives compare_arbiter with directed and random request and operand
//   patterns. A reference model tracks arbitration, transaction timing and
//   the completion count. Expected results are queued at the grant edge.
//   A monitor pops and compares them whenever rsp_valid is seen.
module tb_compare_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] gnt;
  logic       busy;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       G, E, L;
  logic [7:0] done_cnt;

  compare_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .G         (G),
    .E         (E),
    .L         (L),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int id;
    bit g;
    bit e;
    bit l;
  } rsp_t;

  rsp_t exp_q[$];

  // Reference model state: m_cool counts the edges left before the arbiter
  // can grant again (a grant occupies three cycles).
  bit       m_live = 0;
  int       m_last = 3;
  int       m_cool = 0;
  int       m_cnt  = 0;
  bit [3:0] m_gnt  = 4'b0;
  bit       m_rv   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] a,
                               input logic [7:0] b, input int n);
    req  = r;
    a_in = a;
    b_in = b;
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model, evaluated on the same edge the DUT samples inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_live = 1;
      m_last = 3;
      m_cool = 0;
      m_cnt  = 0;
      m_gnt  = 4'b0;
      m_rv   = 0;
      exp_q.delete();
    end else if (m_live) begin
      m_gnt = 4'b0;
      m_rv  = 0;
      if (m_cool == 2) begin
        m_cool = 1;
        m_rv   = 1;
      end else if (m_cool == 1) begin
        m_cool = 0;
        if (m_cnt < 255) m_cnt++;
      end else if (req != 4'b0) begin
        int w;
        int av;
        int bv;
        rsp_t r;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (w < 0 && req[c]) w = c;
        end
        av = (int'(a_in) >> (2 * w)) % 4;
        bv = (int'(b_in) >> (2 * w)) % 4;
        r.id = w;
        r.g  = (av > bv);
        r.e  = (av == bv);
        r.l  = (av < bv);
        exp_q.push_back(r);
        m_gnt  = 4'(1 << w);
        m_last = w;
        m_cool = 2;
      end
    end
  end

  // Monitor: per-cycle timing checks, plus scoreboard pops on rsp_valid.
  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("gnt", 32'(gnt), 32'(m_gnt));
      checkOutput("busy", 32'(busy), 32'(m_cool != 0));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      checkOutput("done_cnt", 32'(done_cnt), 32'(m_cnt));
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_rsp: got rsp_id %0d expected no response", rsp_id);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
          checkOutput("G", 32'(G), 32'(e.g));
          checkOutput("E", 32'(E), 32'(e.e));
          checkOutput("L", 32'(L), 32'(e.l));
        end
      end
    end
  end

  task automatic waitCapt();
    int n;
    n = 0;
    while (m_cool != 2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (m_cool != 2) begin
      checks++;
      $display("[TB] FAIL wait_capt: got timeout expected CAPT within 10 cycles");
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0;
    a_in = 8'h00;
    b_in = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_G", 32'(G), 32'd0);
    checkOutput("reset_E", 32'(E), 32'd0);
    checkOutput("reset_L", 32'(L), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;

    $display("[TB] single request, A>B");
    applyStimulus(4'b0001, 8'h02, 8'h01, 1);
    applyStimulus(4'b0000, 8'h02, 8'h01, 4);

    $display("[TB] requester 2 equal then less");
    applyStimulus(4'b0100, 8'h30, 8'h30, 1);
    applyStimulus(4'b0000, 8'h30, 8'h30, 3);
    applyStimulus(4'b0100, 8'h00, 8'h30, 1);
    applyStimulus(4'b0000, 8'h00, 8'h30, 4);

    $display("[TB] fairness with all requesting");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1111, 8'h1B, 8'hE4, 12);
    checkOutput("fair_done_cnt", 32'(done_cnt), 32'd4);

    $display("[TB] wrap from requester 3");
    applyStimulus(4'b1001, 8'hC3, 8'h42, 7);
    applyStimulus(4'b0000, 8'h00, 8'h00, 3);

    $display("[TB] operand isolation");
    applyStimulus(4'b0001, 8'h00, 8'h03, 1);
    applyStimulus(4'b0000, 8'h03, 8'h00, 4);

    $display("[TB] reset in CAPT");
    applyStimulus(4'b0100, 8'h30, 8'h00, 0);
    waitCapt();
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_G", 32'(G), 32'd0);
    checkOutput("midrst_E", 32'(E), 32'd0);
    checkOutput("midrst_L", 32'(L), 32'd0);
    applyStimulus(4'b0100, 8'h20, 8'h10, 1);
    applyStimulus(4'b0000, 8'h00, 8'h00, 4);

    $display("[TB] random traffic to saturation");
    for (int i = 0; i < 900; i++) begin
      applyStimulus(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom), 1);
    end
    checkOutput("sat_done_cnt", 32'(done_cnt), 32'd255);

    $display("[TB] random traffic with resets");
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      applyStimulus(4'($urandom), 8'($urandom), 8'($urandom), 1);
    end
    rst = 1'b0;
    applyStimulus(4'b0000, 8'h00, 8'h00, 6);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/compare_arbiter.md
COMPARE_ARBITER -- requirements
Module: compare_arbiter

Interface
REQ-001 Parameters: none; requester count fixed at 4, operand width fixed at 2 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request per requester; bit i = requester i.
REQ-005 a_in  input  8  operand A; bits [2i+1:2i] belong to requester i (bit 2i+1 = MSB).
REQ-006 b_in  input  8  operand B; same packing as a_in.
REQ-007 gnt  output  4  one-hot grant pulse, registered.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 rsp_valid  output  1  one-cycle pulse; G/E/L/rsp_id valid.
REQ-010 rsp_id  output  2  index of requester owning the current result.
REQ-011 G, E, L  output  1 each  A>B, A==B, A<B for granted pair, unsigned, registered.
REQ-012 done_cnt  output  8  count of completed comparisons, saturating.

Function
REQ-013 FSM states IDLE, CAPT, RESP; encoding free; exactly one state active.
REQ-014 IDLE: if req==0, stay IDLE, gnt=0; else select winner by round-robin, at the edge set gnt to one-hot winner, latch winner's a/b pair and index, go CAPT.
REQ-015 Round-robin: search starts at (last_grant+1) mod 4 and wraps upward; last_grant resets to 3, so requester 0 has first priority after reset.
REQ-016 last_grant updates only on the edge a grant is issued.
REQ-017 CAPT: gnt returns to 0 at the edge leaving CAPT; at that edge G/E/L computed from latched operands are registered, rsp_id set, rsp_valid set 1, go RESP.
REQ-018 RESP: rsp_valid high for exactly this one cycle; at the edge leaving RESP, rsp_valid cleared, done_cnt incremented (holds at 255), go IDLE.
REQ-019 G, E, L, rsp_id hold their last values outside RESP until the next result.
REQ-020 Exactly one of G/E/L is 1 whenever rsp_valid is 1.
REQ-021 Latency: req sampled high in IDLE at edge k -> gnt high cycle k..k+1, rsp_valid high cycle k+1..k+2; back-to-back grants every 3 cycles.
REQ-022 Operands are sampled only at the grant edge; changes on a_in/b_in after grant do not affect the result.
REQ-023 req is ignored in CAPT and RESP; a requester still high on return to IDLE is treated as a new request.
REQ-024 Requester drops req after seeing gnt; a held req is re-served but only after other pending requesters per REQ-015.
REQ-025 A req pulse that rises and falls entirely within CAPT/RESP is lost; no request queuing.

Reset
REQ-026 rst high at an edge forces: state IDLE, gnt=0, busy=0, rsp_valid=0, rsp_id=0, G=0, E=0, L=0, done_cnt=0, last_grant=3.
REQ-027 rst overrides all other activity in any state; an in-flight comparison is discarded, no rsp_valid, no count increment.
REQ-028 First grant possible at the first edge after rst is sampled low.

Verification
REQ-029 Single request: req=0001, a_in[1:0]=2, b_in[1:0]=1 -> gnt=0001 one cycle, then rsp_valid=1, rsp_id=0, G=1,E=0,L=0, done_cnt=1.
REQ-030 Equality/less: requester 2 a=3,b=3 -> E=1 only; next requester 2 a=0,b=3 -> L=1 only, rsp_id=2.
REQ-031 Fairness: req=1111 held constant 12 cycles after reset -> grant order 0,1,2,3, rsp_id sequence 0,1,2,3, done_cnt=4.
REQ-032 Wrap: last grant 3, req=1001 -> grant 0; then req=1001 held -> grant 3.
REQ-033 Reset mid-op: assert rst in CAPT -> next cycle all outputs zero, no rsp_valid, done_cnt unchanged at 0; following req=0100 granted to requester 2 normally.
REQ-034 Saturation and operand isolation: 256 completed compares -> done_cnt=255 held; changing a_in during CAPT leaves result equal to grant-edge operands.
